// File: rtl/melody_sequencer.sv
// Song-memory driven melody sequencer: steps through {frequency, duration} entries and
// drives a registered frequency code to a tone generator, with a silent gap after each note.
module melody_sequencer #(
  parameter int TICKS_PER_BEAT = 12_500_000,
  parameter int GAP_TICKS      = 2_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        loop_en,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [15:0] wr_data,
  output logic [11:0] note,
  output logic        busy,
  output logic        done
);

  localparam longint PLAY_MAX = 15 * longint'(TICKS_PER_BEAT);
  localparam longint CNT_MAX  = (PLAY_MAX > longint'(GAP_TICKS)) ? PLAY_MAX : longint'(GAP_TICKS);
  localparam int     CNT_W    = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  // The LOAD cycle of the next entry supplies the final silent cycle, so the GAP state
  // itself only runs GAP_TICKS-1 cycles and is skipped entirely below two ticks.
  localparam bit               HAS_GAP  = (GAP_TICKS >= 2);
  localparam logic [CNT_W-1:0] TICKS_C  = CNT_W'(TICKS_PER_BEAT);
  localparam logic [CNT_W-1:0] GAP_LOAD = HAS_GAP ? CNT_W'(GAP_TICKS - 2) : {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [15:0]      r_mem [32];
  logic [15:0]      r_rd;
  logic [4:0]       r_addr;
  logic [4:0]       w_addr_nxt;
  logic [11:0]      r_freq;
  logic [11:0]      w_freq_nxt;
  logic [11:0]      r_note;
  logic [11:0]      w_note_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_play_load;
  logic             r_busy;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_advance;

  assign note        = r_note;
  assign busy        = r_busy;
  assign done        = r_done;
  assign w_play_load = CNT_W'(r_rd[3:0]) * TICKS_C - CNT_W'(1);

  // Song memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Next-state, address and counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_cnt_nxt   = r_cnt;
    w_freq_nxt  = r_freq;
    w_done_nxt  = 1'b0;
    w_advance   = 1'b0;
    if (stop) begin
      w_state_nxt = S_IDLE;
      w_addr_nxt  = 5'd0;
      w_cnt_nxt   = {CNT_W{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_addr_nxt  = 5'd0;
            w_state_nxt = S_LOAD;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_LOAD: begin
          if (r_rd[3:0] == 4'd0) begin
            if (loop_en && (r_addr != 5'd0)) begin
              w_addr_nxt  = 5'd0;
              w_state_nxt = S_LOAD;
            end else begin
              w_state_nxt = S_IDLE;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_freq_nxt  = r_rd[15:4];
            w_cnt_nxt   = w_play_load;
            w_state_nxt = S_PLAY;
          end
        end
        S_PLAY: begin
          if (r_cnt != {CNT_W{1'b0}}) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end else if (HAS_GAP) begin
            w_cnt_nxt   = GAP_LOAD;
            w_state_nxt = S_GAP;
          end else begin
            w_advance = 1'b1;
          end
        end
        S_GAP: begin
          if (r_cnt != {CNT_W{1'b0}}) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end else begin
            w_advance = 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase

      // Entry 31 is the last slot: finishing it ends (or restarts) the song.
      if (w_advance) begin
        if (r_addr == 5'd31) begin
          if (loop_en) begin
            w_addr_nxt  = 5'd0;
            w_state_nxt = S_LOAD;
          end else begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_addr_nxt  = r_addr + 5'd1;
          w_state_nxt = S_LOAD;
        end
      end else begin
        w_advance = 1'b0;
      end
    end
  end

  // Output tone follows the state with one register stage; stop silences it at once.
  always_comb begin
    w_note_nxt = 12'd0;
    if (!stop && (r_state == S_PLAY)) begin
      w_note_nxt = r_freq;
    end else begin
      w_note_nxt = 12'd0;
    end
  end

  // State and output registers; the read register prefetches the entry LOAD will see.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= 5'd0;
      r_cnt   <= {CNT_W{1'b0}};
      r_freq  <= 12'd0;
      r_note  <= 12'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rd    <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_freq  <= w_freq_nxt;
      r_note  <= w_note_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= w_done_nxt;
      r_rd    <= r_mem[w_addr_nxt];
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Randomized and directed bench for melody_sequencer, checked against a note-stream model.
module tb_melody_sequencer;

  localparam int T = 4;
  localparam int G = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = 5'd0;
  logic [15:0] wr_data = 16'd0;
  logic [11:0] note;
  logic        busy;
  logic        done;

  melody_sequencer #(.TICKS_PER_BEAT(T), .GAP_TICKS(G)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .note(note), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [15:0] m_mem [32];
  int exp_note[$];
  bit exp_busy[$];
  bit exp_done[$];
  bit arm_chk = 1'b0;
  bit run = 1'b0;
  int k = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  // Expected per-edge outputs: index k is the sample just after the k-th edge following
  // the edge that takes start. Each note occupies duration*T samples, every note is
  // followed by G silent samples, a loop restart from an end marker costs one extra silent
  // sample, and the song ends on the last silent sample with done and busy falling.
  task automatic build(input bit lp, input int cap);
    int a;
    int d;
    int f;
    int end_idx;
    bit ended;
    exp_note.delete();
    exp_busy.delete();
    exp_done.delete();
    exp_note.push_back(0);
    exp_note.push_back(0);
    a = 0;
    ended = 1'b0;
    end_idx = 1 << 30;
    while (exp_note.size() < cap) begin
      d = int'(m_mem[a][3:0]);
      f = int'(m_mem[a][15:4]);
      if (d == 0) begin
        if (lp && a != 0) begin
          a = 0;
          exp_note.push_back(0);
          continue;
        end
        ended = 1'b1;
        break;
      end
      repeat (d * T) exp_note.push_back(f);
      repeat (G - 1) exp_note.push_back(0);
      if (a == 31) begin
        if (!lp) begin
          ended = 1'b1;
          break;
        end
        a = 0;
      end else begin
        a++;
      end
      exp_note.push_back(0);
    end
    if (ended) begin
      end_idx = exp_note.size() - 1;
      exp_note.push_back(0);
      exp_note.push_back(0);
    end else begin
      while (exp_note.size() > cap) void'(exp_note.pop_back());
    end
    for (int i = 0; i < exp_note.size(); i++) begin
      exp_busy.push_back(i < end_idx);
      exp_done.push_back(i == end_idx);
    end
  endtask

  // Compare process: walks the expected stream once a checked start has been taken.
  always @(posedge clk) begin
    #1;
    if (!run && arm_chk && start) begin
      run = 1'b1;
      k = 0;
    end
    if (run) begin
      total++;
      if (note !== 12'(exp_note[k]) || busy !== exp_busy[k] || done !== exp_done[k]) begin
        bad++;
        $display("FAIL stream k=%0d note=%0d/%0d busy=%0b/%0b done=%0b/%0b",
                 k, note, exp_note[k], busy, exp_busy[k], done, exp_done[k]);
      end
      k++;
      if (k >= exp_note.size()) run = 1'b0;
    end
  end

  task automatic wr(input int a, input logic [15:0] d);
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = 5'(a);
    wr_data = d;
    m_mem[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic play(input bit lp, input int cap, input int wa, input logic [15:0] wd);
    int n;
    loop_en = lp;
    build(lp, cap);
    arm_chk = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = exp_note.size() + 1;
    for (int i = 0; i < n; i++) begin
      if (i == 3 && wa >= 0) begin
        wr_en = 1'b1;
        wr_addr = 5'(wa);
        wr_data = wd;
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
    end
    wr_en = 1'b0;
    arm_chk = 1'b0;
    if (lp) begin
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check("stop_note", note, 0);
      check("stop_busy", busy, 0);
      loop_en = 1'b0;
    end
  endtask

  task automatic song_a();
    wr(0, {12'd440, 4'd2});
    wr(1, {12'd262, 4'd1});
    wr(2, 16'd0);
  endtask

  initial begin
    bit saw_busy;
    bit saw_done;
    int len;

    repeat (3) @(negedge clk);
    check("rst_note", note, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;

    // basic song, with the model pinned to hand-derived values
    song_a();
    build(1'b0, 1000);
    check("model_len", exp_note.size(), 20);
    check("model_first", exp_note[2], 440);
    check("model_440_last", exp_note[9], 440);
    check("model_gap0", exp_note[10], 0);
    check("model_gap1", exp_note[11], 0);
    check("model_262", exp_note[12], 262);
    check("model_262_last", exp_note[15], 262);
    check("model_busy16", exp_busy[16], 1);
    check("model_busy17", exp_busy[17], 0);
    check("model_done17", exp_done[17], 1);
    play(1'b0, 1000, -1, 16'd0);

    // looping never signals done
    play(1'b1, 60, -1, 16'd0);

    // rest entry between notes
    wr(1, {12'd0, 4'd3});
    wr(2, {12'd262, 4'd1});
    wr(3, 16'd0);
    build(1'b0, 1000);
    check("model_rest_end", exp_note[25], 0);
    check("model_after_rest", exp_note[26], 262);
    play(1'b0, 1000, -1, 16'd0);

    // stop together with a start re-pulse in the middle of the first note
    song_a();
    loop_en = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_note", note, 440);
    stop = 1'b1;
    start = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    start = 1'b0;
    check("stop_now_note", note, 0);
    check("stop_now_busy", busy, 0);
    check("stop_now_done", done, 0);
    saw_busy = 1'b0;
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
      if (done) saw_done = 1'b1;
    end
    check("stop_no_restart", saw_busy, 0);
    check("stop_no_done", saw_done, 0);

    // asynchronous reset between clock edges, then an identical replay
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_note", note, 440);
    #2 rst = 1'b1;
    #1;
    check("async_rst_note", note, 0);
    check("async_rst_busy", busy, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    saw_busy = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (busy || note != 12'd0) saw_busy = 1'b1;
    end
    check("no_resume", saw_busy, 0);
    play(1'b0, 1000, -1, 16'd0);

    // overwrite entry 1 while entry 0 is still sounding
    m_mem[1] = {12'd523, 4'd1};
    build(1'b0, 1000);
    check("model_523", exp_note[12], 523);
    play(1'b0, 1000, 1, {12'd523, 4'd1});

    // end marker at entry 0 ends at once even when looping
    wr(0, 16'd0);
    play(1'b1, 50, -1, 16'd0);

    // random songs
    repeat (6) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        wr(i, {12'($urandom_range(0, 4095)), 4'($urandom_range(1, 3))});
      end
      wr(len, {12'($urandom_range(0, 4095)), 4'd0});
      play(1'b0, 1000, -1, 16'd0);
    end
    len = $urandom_range(2, 4);
    for (int i = 0; i < len; i++) begin
      wr(i, {12'($urandom_range(1, 4095)), 4'($urandom_range(1, 2))});
    end
    wr(len, 16'd0);
    play(1'b1, 120, -1, 16'd0);

    // full 32-entry song: ends after entry 31, or wraps when looping
    for (int i = 0; i < 32; i++) begin
      wr(i, {12'($urandom_range(1, 4095)), 4'd1});
    end
    play(1'b0, 1000, -1, 16'd0);
    play(1'b1, 260, -1, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/melody_sequencer.md
MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
REQ-001 SHALL have parameter TICKS_PER_BEAT, default 12_500_000, clk cycles per duration unit (4 beats/s at 50 MHz).
REQ-002 SHALL have parameter GAP_TICKS, default 2_500_000, silent clk cycles inserted after every note.
REQ-003 SHALL have port clk  input  1  single system clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin playback at entry 0.
REQ-006 SHALL have port stop  input  1  abort playback.
REQ-007 SHALL have port loop_en  input  1  restart at entry 0 instead of finishing at end of song.
REQ-008 SHALL have port wr_en  input  1  song-memory write strobe.
REQ-009 SHALL have port wr_addr  input  5  song-memory write address.
REQ-010 SHALL have port wr_data  input  16  entry: [15:4] frequency in Hz, [3:0] duration in beats.
REQ-011 SHALL have port note  output  12  frequency code to the tone generator; 0 = silence.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse on natural end of song.

Function
REQ-014 SHALL hold a 32x16 song memory: synchronous write, registered read, contents not cleared by rst.
REQ-015 SHALL implement states IDLE, LOAD, PLAY, GAP.
REQ-016 IDLE: note=0; when start=1 and stop=0, SHALL clear the address to 0 and go to LOAD.
REQ-017 LOAD (1 cycle): SHALL latch the entry at the current address; duration 0 = end marker.
REQ-018 End marker in LOAD: loop_en=1 -> address 0, stay in LOAD; loop_en=0 -> pulse done, go to IDLE; an end marker at address 0 with loop_en=1 SHALL instead go to IDLE, pulse done.
REQ-019 Non-zero duration in LOAD: SHALL go to PLAY, drive note=frequency (0 = rest) for exactly duration*TICKS_PER_BEAT cycles.
REQ-020 PLAY expiry: SHALL go to GAP, note=0 for exactly GAP_TICKS cycles (skipped if GAP_TICKS=0), then increment the address and go to LOAD.
REQ-021 After entry 31 completes, SHALL treat the song as ended (as REQ-018) rather than wrap silently.
REQ-022 Output note SHALL be registered; first note visible on the 2nd rising edge after the edge sampling start.
REQ-023 stop=1 in any state SHALL force IDLE and note=0 on the next edge, with no done pulse; stop beats simultaneous start.
REQ-024 start while busy SHALL be ignored.
REQ-025 Writes SHALL be accepted in every state; a write to the address being read in the same cycle returns the old data.
REQ-026 Duration counter SHALL be wide enough for 15*TICKS_PER_BEAT without overflow.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, note=0, busy=0, done=0, address=0, counters=0, regardless of clk.
REQ-028 Reset asserted mid-note SHALL silence note asynchronously; playback SHALL NOT resume after release without a new start.

Verification (TICKS_PER_BEAT=4, GAP_TICKS=2)
REQ-029 Write {440,2},{262,1},{0,0}; pulse start -> note=440 for 8 cycles, 0 for 2, 262 for 4, 0 for 2, done pulse 1 cycle, busy falls.
REQ-030 Same song, loop_en=1 -> 440/262 sequence repeats at least twice, done never asserts.
REQ-031 Entry {0,3} between notes -> note=0 for 12+2 cycles, then next note.
REQ-032 stop during the 440 note, same cycle as start re-pulse -> note=0 and IDLE next edge, no done, no restart.
REQ-033 Async rst mid-PLAY between clk edges -> note=0, busy=0 immediately; memory retained, start replays identically.
REQ-034 Overwrite entry 1 with {523,1} while entry 0 plays -> entry 1 plays 523.
